// File: rtl/csa_pipe_adder_pkg.sv
// Purpose: shared defaults and helpers for the carry-skip pipeline adder.
// Latency: n/a (types, constants and a combinational helper).
// Backpressure: n/a.
package csa_pipe_adder_pkg;

  localparam int CSA_WIDTH_DEFAULT = 16;
  localparam int CSA_BLK_DEFAULT   = 4;

  // Signed overflow from the MSB column: the carry into the MSB is recovered
  // from its sum bit (s = a ^ b ^ c_in), then compared with the carry out.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic c_out);
    return (s_msb ^ a_msb ^ b_msb) ^ c_out;
  endfunction

endpackage

// File: rtl/csa_block.sv
// Purpose: combinational BLK-bit ripple adder with carry-skip mux.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage decides when to capture.
// Ports: a, b (block operands), c_in (block carry in) -> s (block sum),
//        c_out (block carry out), skip (carry taken from the skip path).
module csa_block
  import csa_pipe_adder_pkg::*;
#(
  parameter int BLK = CSA_BLK_DEFAULT
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           c_in,
  output logic [BLK-1:0] s,
  output logic           c_out,
  output logic           skip
);

  logic [BLK-1:0] p;
  logic [BLK-1:0] g;
  logic           ripple_c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic c;
    c = c_in;
    s = '0;
    for (int i = 0; i < BLK; i++) begin
      s[i] = p[i] ^ c;
      c    = g[i] | (p[i] & c);
    end
    ripple_c = c;
  end

  // When every bit propagates the block carry is just c_in, so bypass the ripple chain.
  assign skip  = &p;
  assign c_out = skip ? c_in : ripple_c;

endmodule

// File: rtl/csa_defs.vh
// Purpose: shared helpers for the carry-skip pipeline adder (block count, geometry check).
// Latency: n/a (elaboration-time macros only).
// Backpressure: n/a.
`ifndef CSA_DEFS_VH
`define CSA_DEFS_VH

// Number of skip blocks, which is also the pipeline depth.
`define CSA_NBLK(w, b) ((w) / (b))

// Elaboration guard: operand width must be a nonzero multiple of the block size.
`define CSA_CHECK_GEOMETRY(w, b) \
  if ((((w) % (b)) != 0) || ((w) < (b))) begin : g_csa_geometry_check \
    $error("csa_pipe_adder: WIDTH must be a nonzero multiple of BLK"); \
  end

`endif

// File: rtl/csa_pipe_adder.sv
// Purpose: pipelined carry-skip adder/subtractor, one register stage per BLK-bit block.
// Latency: NBLK cycles from input transfer to out_valid, +1 per stall cycle; 1 op/cycle.
// Backpressure: in_ready = !out_valid | out_ready; when low the whole pipeline freezes.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b, cin, sub;
//        out_valid/out_ready with s, cout, ovf, skip_hits.
`include "csa_defs.vh"

module csa_pipe_adder
  import csa_pipe_adder_pkg::*;
#(
  parameter  int WIDTH = CSA_WIDTH_DEFAULT,
  parameter  int BLK   = CSA_BLK_DEFAULT,
  localparam int NBLK  = `CSA_NBLK(WIDTH, BLK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [NBLK-1:0]  skip_hits
);

  `CSA_CHECK_GEOMETRY(WIDTH, BLK)

  // Per-stage state. Operands are shifted right as blocks are consumed, so every
  // stage works on bits [BLK-1:0]; sum and skip flags shift in from the top so
  // they land fully aligned after the last stage.
  logic             vld_q [NBLK];
  logic [WIDTH-1:0] a_q   [NBLK];
  logic [WIDTH-1:0] bp_q  [NBLK];
  logic [WIDTH-1:0] s_q   [NBLK];
  logic             c_q   [NBLK];
  logic             ovf_q [NBLK];
  logic [NBLK-1:0]  sk_q  [NBLK];

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign in_ready = !vld_q[NBLK-1] | out_ready;
  assign advance  = in_ready;

  // Subtraction is a + ~b + 1; the incoming carry is ignored in that mode.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] bp_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic [NBLK-1:0]  sk_in;
    logic [BLK-1:0]   blk_s;
    logic             blk_c;
    logic             blk_sk;
    logic [WIDTH+BLK-1:0] s_cat;
    logic [NBLK:0]        sk_cat;

    if (k == 0) begin : g_first
      assign v_in  = in_valid;
      assign a_in  = a;
      assign bp_in = b_eff;
      assign s_in  = '0;
      assign c_in  = c0;
      assign sk_in = '0;
    end else begin : g_next
      assign v_in  = vld_q[k-1];
      assign a_in  = a_q[k-1];
      assign bp_in = bp_q[k-1];
      assign s_in  = s_q[k-1];
      assign c_in  = c_q[k-1];
      assign sk_in = sk_q[k-1];
    end

    csa_block #(.BLK(BLK)) u_blk (
      .a     (a_in[BLK-1:0]),
      .b     (bp_in[BLK-1:0]),
      .c_in  (c_in),
      .s     (blk_s),
      .c_out (blk_c),
      .skip  (blk_sk)
    );

    assign s_cat  = {blk_s, s_in};
    assign sk_cat = {blk_sk, sk_in};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        ovf_q[k] <= 1'b0;
        sk_q[k]  <= '0;
      end else if (advance) begin
        vld_q[k] <= v_in;
        a_q[k]   <= a_in >> BLK;
        bp_q[k]  <= bp_in >> BLK;
        s_q[k]   <= s_cat[WIDTH+BLK-1:BLK];
        c_q[k]   <= blk_c;
        // Only meaningful in the last stage, where this block holds the MSB.
        ovf_q[k] <= signed_ovf(a_in[BLK-1], bp_in[BLK-1], blk_s[BLK-1], blk_c);
        sk_q[k]  <= sk_cat[NBLK:1];
      end
    end
  end

  assign out_valid = vld_q[NBLK-1];
  assign s         = s_q[NBLK-1];
  assign cout      = c_q[NBLK-1];
  assign ovf       = ovf_q[NBLK-1];
  assign skip_hits = sk_q[NBLK-1];

endmodule
